// File: rtl/instr_load_ctrl.sv
// Instruction-buffer loader: accepts host words, writes them into the buffer and
// releases the fetch stage when loading completes. Optional macro: LOAD_CHECKSUM_EN.
module instr_load_ctrl #(
    parameter int MAX_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        host_valid,
    input  logic [31:0] host_data,
    input  logic        host_last,
    output logic        host_ready,
    output logic        load_en,
    output logic [8:0]  instr_load_addr,
    output logic [31:0] instruction_in,
    output logic        fetch_hold,
    output logic        done,
    output logic [9:0]  load_count,
    output logic        overflow,
    output logic [31:0] checksum
);

    localparam logic [9:0] LAST_IDX = 10'(MAX_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_RUN} state_t;

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [8:0]  r_addr;
    logic [31:0] r_data;
    logic        r_host_ready;
    logic        r_load_en;
    logic        r_fetch_hold;
    logic        r_done;
    logic        r_overflow;

    logic w_xfer;
    logic w_term;
    logic w_reload;

    assign w_xfer   = (r_state == S_LOAD) && host_valid;
    assign w_term   = w_xfer && (host_last || (r_cnt == LAST_IDX));
    assign w_reload = start && ((r_state == S_IDLE) || (r_state == S_RUN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_host_ready <= 1'b0;
            r_load_en    <= 1'b0;
            r_fetch_hold <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_load_en <= w_xfer;
            r_done    <= 1'b0;
            if (w_xfer) begin
                r_addr <= r_cnt[8:0];
                r_data <= host_data;
                r_cnt  <= r_cnt + 10'd1;
            end
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (w_reload) begin
                        r_state      <= S_LOAD;
                        r_host_ready <= 1'b1;
                        r_fetch_hold <= 1'b1;
                        r_cnt        <= '0;
                        r_overflow   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Leaving on the final word; hitting capacity without host_last is an overflow.
                    if (w_term) begin
                        r_state      <= S_DONE;
                        r_host_ready <= 1'b0;
                        r_done       <= 1'b1;
                        if (!host_last) r_overflow <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state      <= S_RUN;
                    r_fetch_hold <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LOAD_CHECKSUM_EN
    logic [31:0] r_cksum;

    always_ff @(posedge clk) begin
        if (rst || w_reload) r_cksum <= '0;
        else if (w_xfer)     r_cksum <= r_cksum ^ host_data;
    end

    assign checksum = r_cksum;
`else
    assign checksum = '0;
`endif

    assign host_ready      = r_host_ready;
    assign load_en         = r_load_en;
    assign instr_load_addr = r_addr;
    assign instruction_in  = r_data;
    assign fetch_hold      = r_fetch_hold;
    assign done            = r_done;
    assign load_count      = r_cnt;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_instr_load_ctrl.sv
// Scoreboard bench for instr_load_ctrl (MAX_WORDS=4): stimulus pushes expected writes,
// a negedge monitor pops and compares them whenever load_en is seen.
module tb_instr_load_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_last;
    logic        host_ready;
    logic        load_en;
    logic [8:0]  instr_load_addr;
    logic [31:0] instruction_in;
    logic        fetch_hold;
    logic        done;
    logic [9:0]  load_count;
    logic        overflow;
    logic [31:0] checksum;

    instr_load_ctrl #(.MAX_WORDS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .host_valid      (host_valid),
        .host_data       (host_data),
        .host_last       (host_last),
        .host_ready      (host_ready),
        .load_en         (load_en),
        .instr_load_addr (instr_load_addr),
        .instruction_in  (instruction_in),
        .fetch_hold      (fetch_hold),
        .done            (done),
        .load_count      (load_count),
        .overflow        (overflow),
        .checksum        (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
        logic [9:0]  c;
        logic [31:0] k;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          m_cnt  = 0;
    logic [31:0] m_ck   = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_ck  = '0;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic acc);
        exp_t e;
        host_valid = 1'b1;
        host_data  = d;
        host_last  = last;
        if (acc) begin
`ifdef LOAD_CHECKSUM_EN
            m_ck = m_ck ^ d;
`endif
            e.a = 9'(m_cnt);
            e.d = d;
            e.c = 10'(m_cnt + 1);
            e.k = m_ck;
            sb.push_back(e);
            m_cnt++;
        end
        tick();
        host_valid = 1'b0;
        host_last  = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_host_ready"}, host_ready, 0);
        chk({tag, "_load_en"}, load_en, 0);
        chk({tag, "_addr"}, instr_load_addr, 0);
        chk({tag, "_instr"}, instruction_in, 0);
        chk({tag, "_fetch_hold"}, fetch_hold, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_load_count"}, load_count, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    always @(negedge clk) begin
        if (load_en === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write",
                         instr_load_addr, instruction_in);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", instr_load_addr, e.a);
                chk("wr_data", instruction_in, e.d);
                chk("wr_count", load_count, e.c);
                chk("wr_checksum", checksum, e.k);
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; host_valid = 1'b0; host_data = '0; host_last = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();
        chk("idle_fetch_hold", fetch_hold, 1);
        chk("idle_host_ready", host_ready, 0);

        // Basic three-word load
        start = 1'b1; model_clear();
        tick();
        start = 1'b0;
        chk("load_host_ready", host_ready, 1);
        chk("load_fetch_hold", fetch_hold, 1);
        send(32'h11111111, 1'b0, 1'b1);
        send(32'h22222222, 1'b0, 1'b1);
        send(32'h33333333, 1'b1, 1'b1);
        chk("t1_done", done, 1);
        chk("t1_done_host_ready", host_ready, 0);
        chk("t1_done_fetch_hold", fetch_hold, 1);
        chk("t1_load_count", load_count, 3);
        chk("t1_checksum", checksum, 32'h00000000);
        chk("t1_overflow", overflow, 0);
        tick();
        chk("t1_run_fetch_hold", fetch_hold, 0);
        chk("t1_run_done", done, 0);
        chk("t1_run_host_ready", host_ready, 0);

        // Host words offered in RUN must be ignored
        host_valid = 1'b1; host_data = 32'hDEADBEEF;
        tick();
        tick();
        host_valid = 1'b0;
        chk("run_count_held", load_count, 3);

        // Reload from RUN, gapped valid, start during LOAD
        start = 1'b1; model_clear();
        tick();
        start = 1'b0;
        chk("t2_fetch_hold", fetch_hold, 1);
        chk("t2_host_ready", host_ready, 1);
        chk("t2_load_count", load_count, 0);
        send(32'hA0000001, 1'b0, 1'b1);
        tick();
        send(32'hA0000002, 1'b0, 1'b1);
        tick();
        start = 1'b1;
        send(32'hA0000003, 1'b0, 1'b1);
        start = 1'b0;
        chk("t2_start_ignored_count", load_count, 3);
        send(32'hA0000004, 1'b1, 1'b1);
        chk("t2_done", done, 1);
        chk("t2_overflow", overflow, 0);
        chk("t2_load_count", load_count, 4);
        tick();

        // Overflow: capacity reached without host_last
        start = 1'b1; model_clear();
        tick();
        start = 1'b0;
        send(32'hB0000001, 1'b0, 1'b1);
        send(32'hB0000002, 1'b0, 1'b1);
        send(32'hB0000003, 1'b0, 1'b1);
        send(32'hB0000004, 1'b0, 1'b1);
        chk("t3_overflow", overflow, 1);
        chk("t3_host_ready", host_ready, 0);
        chk("t3_done", done, 1);
        chk("t3_load_count", load_count, 4);
        send(32'hB0000005, 1'b0, 1'b0);
        send(32'hB0000006, 1'b0, 1'b0);
        chk("t3_overflow_sticky", overflow, 1);
        chk("t3_count_held", load_count, 4);

        // Reload clears overflow
        start = 1'b1; model_clear();
        tick();
        start = 1'b0;
        chk("t4_overflow_cleared", overflow, 0);
        chk("t4_load_count", load_count, 0);
        chk("t4_fetch_hold", fetch_hold, 1);

        // Reset mid-load after two transfers, with a competing host word
        send(32'hC0000001, 1'b0, 1'b1);
        send(32'hC0000002, 1'b0, 1'b1);
        rst = 1'b1; host_valid = 1'b1; host_data = 32'hC0000003; start = 1'b1;
        tick();
        host_valid = 1'b0; start = 1'b0;
        chk_reset_vals("midrst");
        tick();
        rst = 1'b0;
        tick();
        send(32'hC0000004, 1'b0, 1'b0);
        chk("postrst_host_ready", host_ready, 0);
        chk("postrst_load_count", load_count, 0);
        tick();
        tick();
        chk("sb_drain", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
